// File: rtl/coincidence_aligner.sv
// Sequences the coincidence recorder CSR: arm an acquisition, sweep one channel's histogram,
// locate the aliased rising edge and program the coincidence sample count (optionally realign).
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | waiting for cmdStart; rejects out-of-range offsets at once
//   S_START    | strobe the start word
//   S_WAIT_BUSY| wait for recorder busy to rise
//   S_WAIT_IDLE| wait for recorder busy to fall (acquisition complete)
//   S_REQ      | strobe the read request for bin bin_q
//   S_WAIT_RB  | wait for settled readback matching bin and channel
//   S_EVAL     | classify bin bin_q, look for an edge against bin_q-1
//   S_EVAL_WRAP| classify bin 0 against bin N-1, decide edge / no edge
//   S_SET_COINC| strobe the coincidence word
//   S_REALIGN  | strobe the realign word
//   S_DONE     | done pulse, errorCode 0
//   S_FAIL     | done pulse, errorCode already latched
module coincidence_aligner #(
   parameter int CHANNEL_COUNT               = 2,
   parameter int CYCLES_PER_ACQUISITION      = 1023,
   parameter int SAMPLE_CLKS_PER_COINCIDENCE = 100,
   parameter int SETTLE_CYCLES               = 8,
   parameter int TIMEOUT_CYCLES              = 1 << 24,
   localparam int MUXSEL_WIDTH = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
   localparam int SUM_WIDTH    = $clog2(CYCLES_PER_ACQUISITION + 1),
   localparam int SCW          = $clog2(SAMPLE_CLKS_PER_COINCIDENCE)
) (
   input  logic                    sysClk,
   input  logic                    sysReset,
   input  logic                    cmdStart,
   input  logic [MUXSEL_WIDTH-1:0] cmdChannel,
   input  logic [SCW-1:0]          cmdOffset,
   input  logic                    cmdRealign,
   output logic                    csrStrobe,
   output logic [31:0]             csrGPIO_OUT,
   input  logic [31:0]             csrIn,
   output logic                    active,
   output logic                    done,
   output logic [2:0]              errorCode,
   output logic                    multiEdge,
   output logic [SCW-1:0]          edgeAddress,
   output logic [SCW-1:0]          coincidenceAddress
);

   localparam int N     = SAMPLE_CLKS_PER_COINCIDENCE;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SUM_WIDTH-1:0] HALF     = SUM_WIDTH'(CYCLES_PER_ACQUISITION / 2);
   localparam logic [SCW-1:0]       LAST_BIN = SCW'(N - 1);
   localparam logic [SCW:0]         N_EXT    = (SCW + 1)'(N);
   localparam logic [TMO_W-1:0]     TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SET_W-1:0]     SET_LOAD = SET_W'(SETTLE_CYCLES);
   localparam logic [1:0]           STROBE_GAP = 2'd2;

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_ACQ_TMO = 3'd1;
   localparam logic [2:0] ERR_RB_TMO  = 3'd2;
   localparam logic [2:0] ERR_NO_EDGE = 3'd3;
   localparam logic [2:0] ERR_OFFSET  = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_IDLE, S_REQ, S_WAIT_RB,
      S_EVAL, S_EVAL_WRAP, S_SET_COINC, S_REALIGN, S_DONE, S_FAIL
   } state_t;

   state_t                  state_q;
   logic [MUXSEL_WIDTH-1:0] ch_q;
   logic [SCW-1:0]          ofs_q;
   logic                    realign_q;
   logic [SCW-1:0]          bin_q;
   logic [TMO_W-1:0]        tmo_q;
   logic [SET_W-1:0]        settle_q;
   logic [1:0]              gap_q;
   logic                    cur_high_q;
   logic                    prev_high_q;
   logic                    high0_q;
   logic [1:0]              edge_cnt_q;
   logic [SCW-1:0]          edge_q;
   logic [SCW-1:0]          coinc_q;
   logic [2:0]              err_q;
   logic                    multi_q;
   logic                    active_q;
   logic                    done_q;
   logic                    strobe_q;
   logic [31:0]             gpio_q;

   logic                    busy_w;
   logic [SCW-1:0]          rb_addr_w;
   logic [MUXSEL_WIDTH-1:0] rb_sel_w;
   logic [SUM_WIDTH-1:0]    rb_count_w;
   logic                    rb_ok_w;
   logic                    rb_high_w;
   logic                    edge_here_w;
   logic                    edge_wrap_w;
   logic [1:0]              edge_cnt_d;
   logic [SCW:0]            sum_w;
   logic [SCW-1:0]          coinc_d;
   logic                    offset_bad_w;
   logic [31:0]             rd_word_w;
   logic [31:0]             coinc_word_w;
   logic                    unused_csr;

   assign busy_w     = csrIn[31];
   assign rb_sel_w   = csrIn[24 +: MUXSEL_WIDTH];
   assign rb_addr_w  = csrIn[SUM_WIDTH +: SCW];
   assign rb_count_w = csrIn[SUM_WIDTH-1:0];
   assign unused_csr = ^{csrIn[30:24+MUXSEL_WIDTH], csrIn[23:SUM_WIDTH+SCW]};

   assign rb_ok_w   = (settle_q == '0) && (rb_addr_w == bin_q) && (rb_sel_w == ch_q);
   assign rb_high_w = rb_count_w > HALF;

   // Bin 0's predecessor is bin N-1, so its edge test runs once the sweep has wrapped.
   assign edge_here_w = cur_high_q & ~prev_high_q;
   assign edge_wrap_w = high0_q & ~prev_high_q;
   assign edge_cnt_d  = (edge_cnt_q == 2'd2) ? 2'd2 : edge_cnt_q + {1'b0, edge_wrap_w};

   assign sum_w   = {1'b0, edge_q} + {1'b0, ofs_q};
   assign coinc_d = (sum_w >= N_EXT) ? SCW'(sum_w - N_EXT) : SCW'(sum_w);

   assign offset_bad_w = {1'b0, cmdOffset} >= N_EXT;

   always_comb begin
      rd_word_w                     = '0;
      rd_word_w[24 +: MUXSEL_WIDTH] = ch_q;
      rd_word_w[SCW-1:0]            = bin_q;
      coinc_word_w                  = '0;
      coinc_word_w[30]              = 1'b1;
      coinc_word_w[SCW-1:0]         = coinc_d;
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         ofs_q       <= '0;
         realign_q   <= 1'b0;
         bin_q       <= '0;
         tmo_q       <= '0;
         settle_q    <= '0;
         gap_q       <= '0;
         cur_high_q  <= 1'b0;
         prev_high_q <= 1'b0;
         high0_q     <= 1'b0;
         edge_cnt_q  <= '0;
         edge_q      <= '0;
         coinc_q     <= '0;
         err_q       <= ERR_OK;
         multi_q     <= 1'b0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         strobe_q    <= 1'b0;
         gpio_q      <= '0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         if (gap_q != '0) gap_q <= gap_q - 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (cmdStart) begin
                  ch_q       <= cmdChannel;
                  ofs_q      <= cmdOffset;
                  realign_q  <= cmdRealign;
                  err_q      <= ERR_OK;
                  multi_q    <= 1'b0;
                  edge_cnt_q <= '0;
                  bin_q      <= '0;
                  if (offset_bad_w) begin
                     err_q  <= ERR_OFFSET;
                     done_q <= 1'b1;
                  end else begin
                     active_q <= 1'b1;
                     state_q  <= S_START;
                  end
               end
            end
            S_START: begin
               if (gap_q == '0) begin
                  strobe_q <= 1'b1;
                  gpio_q   <= 32'h8000_0000;
                  gap_q    <= STROBE_GAP;
                  tmo_q    <= TMO_LOAD;
                  state_q  <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (busy_w) begin
                  tmo_q   <= TMO_LOAD;
                  state_q <= S_WAIT_IDLE;
               end else if (tmo_q == '0) begin
                  err_q   <= ERR_ACQ_TMO;
                  state_q <= S_FAIL;
               end else begin
                  tmo_q <= tmo_q - 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               if (!busy_w) begin
                  state_q <= S_REQ;
               end else if (tmo_q == '0) begin
                  err_q   <= ERR_ACQ_TMO;
                  state_q <= S_FAIL;
               end else begin
                  tmo_q <= tmo_q - 1'b1;
               end
            end
            S_REQ: begin
               if (gap_q == '0) begin
                  strobe_q <= 1'b1;
                  gpio_q   <= rd_word_w;
                  gap_q    <= STROBE_GAP;
                  settle_q <= SET_LOAD;
                  tmo_q    <= TMO_LOAD;
                  state_q  <= S_WAIT_RB;
               end
            end
            S_WAIT_RB: begin
               if (rb_ok_w) begin
                  cur_high_q <= rb_high_w;
                  state_q    <= S_EVAL;
               end else begin
                  if (settle_q != '0) settle_q <= settle_q - 1'b1;
                  if (tmo_q == '0) begin
                     err_q   <= ERR_RB_TMO;
                     state_q <= S_FAIL;
                  end else begin
                     tmo_q <= tmo_q - 1'b1;
                  end
               end
            end
            S_EVAL: begin
               if (bin_q == '0) begin
                  high0_q <= cur_high_q;
               end else if (edge_here_w) begin
                  if (edge_cnt_q == 2'd0) edge_q <= bin_q;
                  if (edge_cnt_q != 2'd2) edge_cnt_q <= edge_cnt_q + 2'd1;
                  if (edge_cnt_q != 2'd0) multi_q <= 1'b1;
               end
               prev_high_q <= cur_high_q;
               if (bin_q == LAST_BIN) begin
                  state_q <= S_EVAL_WRAP;
               end else begin
                  bin_q   <= bin_q + 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_EVAL_WRAP: begin
               edge_cnt_q <= edge_cnt_d;
               if (edge_cnt_d == 2'd0) begin
                  err_q   <= ERR_NO_EDGE;
                  state_q <= S_FAIL;
               end else begin
                  if (edge_wrap_w) edge_q <= '0;
                  if (edge_cnt_d == 2'd2) multi_q <= 1'b1;
                  state_q <= S_SET_COINC;
               end
            end
            S_SET_COINC: begin
               if (gap_q == '0) begin
                  strobe_q <= 1'b1;
                  gpio_q   <= coinc_word_w;
                  gap_q    <= STROBE_GAP;
                  coinc_q  <= coinc_d;
                  state_q  <= realign_q ? S_REALIGN : S_DONE;
               end
            end
            S_REALIGN: begin
               if (gap_q == '0) begin
                  strobe_q <= 1'b1;
                  gpio_q   <= 32'h2000_0000;
                  gap_q    <= STROBE_GAP;
                  state_q  <= S_DONE;
               end
            end
            S_DONE, S_FAIL: begin
               done_q   <= 1'b1;
               active_q <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign csrStrobe          = strobe_q;
   assign csrGPIO_OUT        = gpio_q;
   assign active             = active_q;
   assign done               = done_q;
   assign errorCode          = err_q;
   assign multiEdge          = multi_q;
   assign edgeAddress        = edge_q;
   assign coincidenceAddress = coinc_q;

endmodule

// File: tb/tb_coincidence_aligner.sv
// Scoreboarded bench for coincidence_aligner: a recorder model answers CSR writes, a reference
// model predicts every CSR word and the done result, and a monitor compares as the DUT emits them.
module tb_coincidence_aligner;

   localparam int N      = 100;
   localparam int SETTLE = 8;
   localparam int TMO    = 64;
   localparam int HALF   = 511;

   logic        sysClk = 1'b0;
   logic        sysReset = 1'b1;
   logic        cmdStart = 1'b0;
   logic [0:0]  cmdChannel = '0;
   logic [6:0]  cmdOffset = '0;
   logic        cmdRealign = 1'b0;
   logic        csrStrobe;
   logic [31:0] csrGPIO_OUT;
   logic [31:0] csrIn = '0;
   logic        active;
   logic        done;
   logic [2:0]  errorCode;
   logic        multiEdge;
   logic [6:0]  edgeAddress;
   logic [6:0]  coincidenceAddress;

   coincidence_aligner #(
      .CHANNEL_COUNT(2), .CYCLES_PER_ACQUISITION(1023), .SAMPLE_CLKS_PER_COINCIDENCE(N),
      .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sysClk(sysClk), .sysReset(sysReset), .cmdStart(cmdStart), .cmdChannel(cmdChannel),
      .cmdOffset(cmdOffset), .cmdRealign(cmdRealign), .csrStrobe(csrStrobe),
      .csrGPIO_OUT(csrGPIO_OUT), .csrIn(csrIn), .active(active), .done(done),
      .errorCode(errorCode), .multiEdge(multiEdge), .edgeAddress(edgeAddress),
      .coincidenceAddress(coincidenceAddress)
   );

   always #5 sysClk = ~sysClk;

   int cyc = 0;
   always @(posedge sysClk) cyc <= cyc + 1;

   typedef struct {
      int err;
      int ebin;
      int coinc;
      int multi;
   } done_t;

   logic [31:0] exp_wr[$];
   done_t       exp_done[$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          last_strobe_cyc = -1;
   int          hist[2][N];

   // recorder model state
   int          mdl_mode = 0;   // 0 normal, 1 never busy, 2 stale readback address
   logic        busy = 1'b0;
   int          busy_dly = 0;
   int          busy_len = 0;
   int          rb_pend = 0;
   int          pend_bin = 0;
   int          pend_sel = 0;
   logic [6:0]  rb_addr = '0;
   logic        rb_sel = 1'b0;
   logic [9:0]  rb_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      busy = 1'b0; busy_dly = 0; busy_len = 0; rb_pend = 0;
   endtask

   initial begin : recorder_model
      logic [31:0] w;
      logic [31:0] v;
      forever begin
         @(negedge sysClk);
         if (busy_dly > 0) begin
            busy_dly--;
            if (busy_dly == 0) busy = 1'b1;
         end else if (busy && busy_len > 0) begin
            busy_len--;
            if (busy_len == 0) busy = 1'b0;
         end
         if (rb_pend > 0) begin
            rb_pend--;
            if (rb_pend == 0) begin
               rb_addr = 7'(pend_bin);
               rb_sel  = pend_sel[0];
               rb_cnt  = 10'(hist[pend_sel][pend_bin]);
            end
         end
         if (csrStrobe === 1'b1) begin
            w = csrGPIO_OUT;
            if (w[31]) begin
               if (mdl_mode != 1) begin
                  busy_dly = int'($urandom_range(1, 4));
                  busy_len = int'($urandom_range(3, 20));
               end
            end else if (w[31:29] == 3'b000) begin
               if (mdl_mode == 2) begin
                  rb_addr = 7'd99;
               end else begin
                  pend_bin = int'(w[6:0]) % N;
                  pend_sel = int'(w[24]);
                  rb_pend  = int'($urandom_range(1, SETTLE + 3));
               end
            end
         end
         v = '0;
         v[31] = busy;
         v[24] = rb_sel;
         v[16:10] = rb_addr;
         v[9:0] = rb_cnt;
         csrIn = v;
      end
   end

   initial begin : monitor
      logic [31:0] w;
      done_t d;
      forever begin
         @(negedge sysClk);
         if (csrStrobe === 1'b1) begin
            if (last_strobe_cyc >= 0) begin
               checks++;
               if (cyc - last_strobe_cyc < 2) begin
                  failures++;
                  $display("FAIL strobe_spacing actual=%0d cycles required>=2", cyc - last_strobe_cyc);
               end
            end
            last_strobe_cyc = cyc;
            if (exp_wr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe actual=0x%08h expected=none", csrGPIO_OUT);
            end else begin
               w = exp_wr.pop_front();
               check("csr_word", csrGPIO_OUT, w);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 expected=0 errorCode=%0d", errorCode);
            end else begin
               d = exp_done.pop_front();
               check("errorCode", 32'(errorCode), 32'(d.err));
               check("multiEdge", 32'(multiEdge), 32'(d.multi));
               check("active_at_done", 32'(active), 32'd0);
               if (d.err == 0) begin
                  check("edgeAddress", 32'(edgeAddress), 32'(d.ebin));
                  check("coincidenceAddress", 32'(coincidenceAddress), 32'(d.coinc));
               end
            end
         end
      end
   end

   function automatic bit is_high(input int ch, input int b);
      return hist[ch][b] > HALF;
   endfunction

   task automatic push_expect(input int ch, input int off, input int rl, input int mode);
      done_t d;
      int n_edges;
      int first;
      d.err = 0; d.ebin = 0; d.coinc = 0; d.multi = 0;
      if (off >= N) begin
         d.err = 4; exp_done.push_back(d); return;
      end
      exp_wr.push_back(32'h8000_0000);
      if (mode == 1) begin
         d.err = 1; exp_done.push_back(d); return;
      end
      if (mode == 2) begin
         exp_wr.push_back(32'(ch) << 24);
         d.err = 2; exp_done.push_back(d); return;
      end
      n_edges = 0;
      first = -1;
      for (int b = 0; b < N; b++) begin
         exp_wr.push_back((32'(ch) << 24) | 32'(b));
         if (is_high(ch, b) && !is_high(ch, (b + N - 1) % N)) begin
            if (first < 0) first = b;
            n_edges++;
         end
      end
      if (n_edges == 0) begin
         d.err = 3; exp_done.push_back(d); return;
      end
      d.ebin  = first;
      d.coinc = (first + off) % N;
      d.multi = (n_edges >= 2) ? 1 : 0;
      exp_wr.push_back(32'h4000_0000 | 32'(d.coinc));
      if (rl != 0) exp_wr.push_back(32'h2000_0000);
      exp_done.push_back(d);
   endtask

   task automatic set_range(input int ch, input int lo, input int hi);
      for (int b = 0; b < N; b++)
         hist[ch][b] = (b >= lo && b <= hi) ? int'($urandom_range(512, 1023))
                                            : int'($urandom_range(0, 511));
   endtask

   task automatic set_noise(input int ch);
      for (int b = 0; b < N; b++) hist[ch][b] = int'($urandom_range(0, 1023));
   endtask

   task automatic start_pulse(input int ch, input int off, input int rl);
      @(posedge sysClk); #1;
      cmdChannel = ch[0]; cmdOffset = off[6:0]; cmdRealign = rl[0]; cmdStart = 1'b1;
      @(posedge sysClk); #1;
      cmdStart = 1'b0;
      cmdChannel = ~ch[0]; cmdOffset = 7'($urandom_range(0, 99)); cmdRealign = ~rl[0];
   endtask

   task automatic run(input int ch, input int off, input int rl, input int mode, input bit poke);
      int d0;
      int lat;
      mdl_mode = mode;
      last_strobe_cyc = -1;
      push_expect(ch, off, rl, mode);
      d0 = done_cnt;
      start_pulse(ch, off, rl);
      if (off < N) check("active_running", 32'(active), 32'd1);
      if (poke) begin
         repeat (40) @(posedge sysClk);
         #1 cmdStart = 1'b1; cmdOffset = 7'd100;
         @(posedge sysClk); #1 cmdStart = 1'b0;
      end
      for (int i = 0; i < 6000 && done_cnt == d0; i++) @(posedge sysClk);
      if (done_cnt == d0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done expected=done_within_6000_cycles");
      end else if (mode == 1) begin
         lat = done_cyc - last_strobe_cyc;
         checks++;
         if (lat < TMO || lat > TMO + 2) begin
            failures++;
            $display("FAIL acq_timeout_latency actual=%0d expected=%0d..%0d", lat, TMO, TMO + 2);
         end
      end
      repeat (5) @(posedge sysClk);
      #1;
      check("leftover_writes", 32'(exp_wr.size()), 32'd0);
      check("leftover_done", 32'(exp_done.size()), 32'd0);
      exp_wr.delete();
      exp_done.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_csrStrobe"}, 32'(csrStrobe), 32'd0);
      check({tag, "_csrGPIO_OUT"}, csrGPIO_OUT, 32'd0);
      check({tag, "_active"}, 32'(active), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_errorCode"}, 32'(errorCode), 32'd0);
      check({tag, "_multiEdge"}, 32'(multiEdge), 32'd0);
      check({tag, "_edgeAddress"}, 32'(edgeAddress), 32'd0);
      check({tag, "_coincidence"}, 32'(coincidenceAddress), 32'd0);
   endtask

   initial begin : main
      int d0;
      set_noise(0);
      set_noise(1);
      repeat (3) @(posedge sysClk);
      #1 sysReset = 1'b0;
      @(negedge sysClk);
      check_all_zero("reset");

      // low 0..39, high 40..99, with the 511/512 threshold on the boundary bins
      set_range(1, 40, 99);
      hist[1][39] = 511;
      hist[1][40] = 512;
      run(1, 5, 0, 0, 1'b0);
      run(1, 70, 1, 0, 1'b1);

      set_range(0, 60, 99);
      hist[0][0] = 900;
      run(0, 3, 0, 0, 1'b0);
      set_range(0, 0, 59);
      run(0, 99, 1, 0, 1'b0);

      for (int b = 0; b < N; b++) hist[1][b] = 200;
      run(1, 10, 1, 0, 1'b0);

      set_range(0, 20, 49);
      for (int b = 70; b < N; b++) hist[0][b] = 700;
      run(0, 0, 0, 0, 1'b0);

      run(0, 5, 0, 1, 1'b1);
      run(1, 5, 0, 2, 1'b0);
      run(1, 100, 0, 0, 1'b0);

      // reset in the middle of a sweep
      set_range(0, 30, 80);
      mdl_mode = 0;
      last_strobe_cyc = -1;
      push_expect(0, 7, 1, 0);
      d0 = done_cnt;
      start_pulse(0, 7, 1);
      repeat (300) @(posedge sysClk);
      #1 sysReset = 1'b1;
      @(posedge sysClk); #1;
      exp_wr.delete();
      exp_done.delete();
      model_clear();
      check_all_zero("midreset");
      sysReset = 1'b0;
      repeat (300) @(posedge sysClk);
      #1;
      check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
      run(0, 7, 1, 0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int ch;
         int lo;
         ch = int'($urandom_range(0, 1));
         set_noise(1 - ch);
         if ($urandom_range(0, 2) == 0) begin
            set_noise(ch);
         end else begin
            lo = int'($urandom_range(0, 99));
            set_range(ch, lo, lo + int'($urandom_range(0, 98)));
            for (int b = N; b < 2 * N; b++)
               if (b <= lo + 98 && hist[ch][b - N] < 512 && b - N < lo) hist[ch][b - N] = 0;
         end
         run(ch, int'($urandom_range(0, 99)), int'($urandom_range(0, 1)), 0,
             1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
